dcache_refill_ctrl: RTL
=======================

// Module: dcache_refill_ctrl
// PURPOSE
//   Sequences one D-cache line miss: optional dirty-victim writeback, 16-beat AXI read burst, return-buffer fill.
//   Sits between the D-cache main FSM and the AXI bridge; drives the return buffer's beat stream and the cache array write strobe.
//   Handles one outstanding miss at a time; reports done or error back to the cache FSM.
// PARAMETERS
//   LINE_WORDS  16  32-bit words per cache line (burst length); power of two
//   ADDR_W      32  physical address width
//   OFF_W       6   line offset bits, log2(LINE_WORDS*4)
// PORTS
//   clk          in   1       clock, rising edge
//   rstn         in   1       synchronous reset, active-low
//   miss_req     in   1       cache requests a refill; sampled only in IDLE
//   miss_addr    in   ADDR_W  missing address; latched line-aligned (low OFF_W bits zeroed)
//   miss_dirty   in   1       victim line dirty, writeback required
//   victim_addr  in   ADDR_W  victim line address, latched line-aligned
//   rd_req       out  1       AXI read burst request
//   rd_addr      out  ADDR_W  burst address (latched miss line)
//   rd_rdy       in   1       bridge accepted read request
//   ret_valid    in   1       read data beat valid
//   ret_last     in   1       final beat of burst
//   wr_req       out  1       AXI writeback burst request
//   wr_addr      out  ADDR_W  writeback address (latched victim line)
//   wr_rdy       in   1       bridge accepted writeback (data taken from victim buffer)
//   wr_done      in   1       write response received
//   buf_clr      out  1       one-cycle pulse: clear return buffer / beat index before burst
//   beat_idx     out  4       index of the next expected return beat
//   fill_we      out  1       one-cycle pulse: write assembled line into data/tag arrays
//   miss_busy    out  1       high in every state except IDLE
//   miss_done    out  1       one-cycle pulse: refill complete, cache FSM may replay
//   miss_err     out  1       one-cycle pulse with miss_done: beat-count mismatch
// BEHAVIOUR
//   Reset (rstn=0 at clk edge): state=IDLE; all outputs 0; beat_idx=0; latched addresses 0.
//   Reset overrides any in-flight transaction; bridge must be reset in the same cycle.
//   IDLE: miss_req=1 -> latch addrs/dirty; next WB_REQ if dirty else RD_REQ. miss_req=0 -> stay.
//   WB_REQ: wr_req=1 held until wr_rdy=1 -> WB_WAIT. wr_addr stable while wr_req high.
//   WB_WAIT: wait wr_done=1 -> RD_REQ. Read never issued before writeback response (RAW safety).
//   RD_REQ: rd_req=1 and buf_clr=1 on entry cycle only; rd_req held until rd_rdy=1 -> RD_DATA.
//   RD_DATA: each ret_valid=1 cycle increments beat_idx (4-bit, wraps 15->0).
//     ret_last=1 with ret_valid -> FILL; err flag set if beat_idx != LINE_WORDS-1 that cycle.
//     ret_valid=0 cycles: hold; no timeout.
//   FILL: fill_we=1 for exactly one cycle -> DONE.
//   DONE: miss_done=1 (and miss_err=err flag) one cycle; beat_idx cleared; -> IDLE.
//   Latency, no backpressure, dirty=0: miss_req cycle N -> rd_req at N+1; last beat L -> fill_we L+1, miss_done L+2.
//   miss_req asserted while busy: ignored; cache FSM must hold it until miss_done.
//   rd_rdy/wr_rdy asserted same cycle request first rises: accepted, advance next cycle.
//   wr_done or ret_valid outside its state: ignored, no state change.
// STRUCTURE
//   Shared package dcache_pkg: state enum (IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_DATA, FILL, DONE),
//   LINE_WORDS/OFF_W constants, line_align() function. No sub-module; FSM + beat counter in one file.
// TESTING
//   Clean miss: miss_req, dirty=0, addr 0x1C00_0074 -> rd_addr=0x1C00_0040, 16 beats, fill_we 1 cycle, miss_done, err=0.
//   Dirty miss: victim 0x0000_8FC0 -> wr_req first, rd_req only after wr_done; rd_req low throughout WB states.
//   Backpressure: rd_rdy low 5 cycles, ret_valid gaps every other beat -> rd_req held stable, beat_idx counts 16 only.
//   Short burst: ret_last on beat 12 -> fill_we then miss_done with miss_err=1, return to IDLE.
//   Reset mid-RD_DATA after beat 7 -> next cycle IDLE, all outputs 0, beat_idx=0; new miss completes normally.
//   Busy miss_req: second miss_req during RD_DATA with new addr -> ignored, rd_addr unchanged.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the D-cache refill path: FSM states, line geometry and
// the helper that strips the line offset from an address.
package dcache_pkg;

    localparam int LINE_WORDS = 16;
    localparam int ADDR_W     = 32;
    localparam int OFF_W      = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        FILL    = 3'd5,
        DONE    = 3'd6
    } state_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_refill_ctrl.sv
// Sequences a single D-cache miss: optional victim writeback, one read burst,
// beat counting into the return buffer, array fill and done/error report.
module dcache_refill_ctrl #(
    parameter int LINE_WORDS = dcache_pkg::LINE_WORDS,
    parameter int ADDR_W     = dcache_pkg::ADDR_W,
    parameter int OFF_W      = dcache_pkg::OFF_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              miss_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_rdy,
    input  logic              wr_done,
    output logic              buf_clr,
    output logic [3:0]        beat_idx,
    output logic              fill_we,
    output logic              miss_busy,
    output logic              miss_done,
    output logic              miss_err
);
    import dcache_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(LINE_WORDS - 1);

    state_t            state_reg, state_next;
    logic [3:0]        beat_idx_reg, beat_idx_next;
    logic              err_reg, err_next;
    logic              rd_first_reg, rd_first_next;
    logic [ADDR_W-1:0] rd_line_reg, rd_line_next;
    logic [ADDR_W-1:0] wr_line_reg, wr_line_next;
    logic [ADDR_W-1:0] miss_line, victim_line;

    // Default geometry reuses the shared helper; other widths mask locally.
    generate
        if (ADDR_W == dcache_pkg::ADDR_W && OFF_W == dcache_pkg::OFF_W) begin : g_pkg_align
            assign miss_line   = line_align(miss_addr);
            assign victim_line = line_align(victim_addr);
        end else begin : g_local_align
            assign miss_line   = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            assign victim_line = {victim_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            beat_idx_reg <= 4'd0;
            err_reg      <= 1'b0;
            rd_first_reg <= 1'b0;
            rd_line_reg  <= '0;
            wr_line_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            beat_idx_reg <= beat_idx_next;
            err_reg      <= err_next;
            rd_first_reg <= rd_first_next;
            rd_line_reg  <= rd_line_next;
            wr_line_reg  <= wr_line_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        beat_idx_next = beat_idx_reg;
        err_next      = err_reg;
        rd_first_next = 1'b0;
        rd_line_next  = rd_line_reg;
        wr_line_next  = wr_line_reg;

        case (state_reg)
            IDLE: begin
                if (miss_req) begin
                    rd_line_next = miss_line;
                    wr_line_next = victim_line;
                    err_next     = 1'b0;
                    if (miss_dirty) begin
                        state_next = WB_REQ;
                    end else begin
                        state_next    = RD_REQ;
                        rd_first_next = 1'b1;
                    end
                end
            end
            WB_REQ: begin
                if (wr_rdy) state_next = WB_WAIT;
            end
            WB_WAIT: begin
                // The read must not overtake the victim writeback response.
                if (wr_done) begin
                    state_next    = RD_REQ;
                    rd_first_next = 1'b1;
                end
            end
            RD_REQ: begin
                if (rd_first_reg) beat_idx_next = 4'd0;
                if (rd_rdy) state_next = RD_DATA;
            end
            RD_DATA: begin
                if (ret_valid) begin
                    beat_idx_next = beat_idx_reg + 4'd1;
                    if (ret_last) begin
                        err_next   = (beat_idx_reg != LAST_IDX);
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                state_next = DONE;
            end
            DONE: begin
                beat_idx_next = 4'd0;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rd_req    = (state_reg == RD_REQ);
    assign buf_clr   = (state_reg == RD_REQ) && rd_first_reg;
    assign wr_req    = (state_reg == WB_REQ);
    assign fill_we   = (state_reg == FILL);
    assign miss_done = (state_reg == DONE);
    assign miss_err  = (state_reg == DONE) && err_reg;
    assign miss_busy = (state_reg != IDLE);
    assign rd_addr   = rd_line_reg;
    assign wr_addr   = wr_line_reg;
    assign beat_idx  = beat_idx_reg;

endmodule
